// File: rtl/fpu_line_unpacker.sv
// Unpacks 64-byte DRAM lines MSB-first into one FPU input buffer row, one byte per cycle.
// Optional sticky error flag enabled by defining FPU_UNPACK_ERR_EN.
module fpu_line_unpacker #(
   parameter int BUFFER_DEPTH = 512,
   parameter int COL_WIDTH    = 10
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic                                              start,
   input  logic [16:0]                                       width,
   input  logic [$clog2(COL_WIDTH)-1:0]                      row_sel,
   input  logic [511:0]                                      dram_data,
   input  logic                                              dram_valid,
   output logic                                              line_ready,
   output logic                                              buf_wr_en,
   output logic [$clog2(COL_WIDTH)+$clog2(BUFFER_DEPTH)-1:0] buf_wr_addr,
   output logic [7:0]                                        buf_wr_data,
   output logic                                              busy,
   output logic                                              done,
   output logic                                              err
);

   localparam int ROW_W = $clog2(COL_WIDTH);
   localparam int COL_W = $clog2(BUFFER_DEPTH);
   localparam int WID_W = $clog2(BUFFER_DEPTH + 1);
   localparam logic [16:0] MAX_WIDTH = 17'(BUFFER_DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT_LINE, UNPACK, DONE} state_t;

   state_t             state, next_state;
   logic [WID_W-1:0]   width_q, lines_expected, lines_rcvd;
   logic [ROW_W-1:0]   row_q;
   logic [COL_W-1:0]   col;
   logic [5:0]         byte_cnt;
   logic [511:0]       shreg;

   logic               width_over;
   logic [WID_W-1:0]   width_clamped;
   logic               accept_start, accept_line;
   logic               row_end, line_end, last_write;

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      width_over    = width > MAX_WIDTH;
      width_clamped = width_over ? WID_W'(BUFFER_DEPTH) : WID_W'(width);
      accept_start  = (state == IDLE) && start;
      accept_line   = (state == WAIT_LINE) && dram_valid && line_ready;
      row_end       = (WID_W'(col) + WID_W'(1)) == width_q;
      line_end      = byte_cnt == 6'd63;
      last_write    = (state == UNPACK) && (row_end || line_end);

      next_state = state;
      case (state)
         IDLE:      if (start) next_state = (width_clamped == '0) ? DONE : WAIT_LINE;
         WAIT_LINE: if (accept_line) next_state = UNPACK;
         UNPACK:    if (last_write)
                       next_state = (lines_rcvd == lines_expected) ? DONE : WAIT_LINE;
         DONE:      next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         line_ready     <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         buf_wr_en      <= 1'b0;
         buf_wr_addr    <= '0;
         buf_wr_data    <= '0;
         width_q        <= '0;
         lines_expected <= '0;
         lines_rcvd     <= '0;
         row_q          <= '0;
         col            <= '0;
         byte_cnt       <= '0;
      end else begin
         state      <= next_state;
         // Outputs are decoded from the next state so they are registered yet aligned with it.
         line_ready <= next_state == WAIT_LINE;
         busy       <= next_state != IDLE;
         done       <= next_state == DONE;
         buf_wr_en  <= next_state == UNPACK;

         case (state)
            IDLE: if (accept_start) begin
               width_q        <= width_clamped;
               row_q          <= row_sel;
               lines_expected <= (width_clamped >> 6) + WID_W'(|width_clamped[5:0]);
               lines_rcvd     <= '0;
               col            <= '0;
               byte_cnt       <= '0;
            end
            WAIT_LINE: if (accept_line) begin
               buf_wr_data <= dram_data[511:504];
               buf_wr_addr <= {row_q, col};
               lines_rcvd  <= lines_rcvd + WID_W'(1);
               byte_cnt    <= '0;
            end
            UNPACK: begin
               byte_cnt <= byte_cnt + 6'd1;
               if (!row_end) col <= col + COL_W'(1);
               if (!last_write) begin
                  buf_wr_data <= shreg[511:504];
                  buf_wr_addr <= {row_q, col + COL_W'(1)};
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the line shift register is pure datapath, always loaded before it is read, so it has no reset.
   always_ff @(posedge clk) begin
      if (accept_line)
         shreg <= dram_data << 8;
      else if (state == UNPACK)
         shreg <= shreg << 8;
   end

`ifdef FPU_UNPACK_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else if ((dram_valid && !line_ready) || (accept_start && width_over))
         err <= 1'b1;
      else if (accept_start)
         err <= 1'b0;
   end
`else
   assign err = 1'b0;
`endif

endmodule
